// File: rtl/id_alu_issue.sv
// Decode-side issue stage. Decodes a MIPS R/I-type subset into ALU operands,
// function code and destination, and buffers the result in a 2-entry skid
// register with valid/ready handshakes on both sides.
module id_alu_issue #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_OP   = 6,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [31:0]        i_instr,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ex_ready,
  output logic [NB_DATA-1:0] o_data_1,
  output logic [NB_DATA-1:0] o_data_2,
  output logic [NB_OP-1:0]   o_code,
  output logic [NB_REG-1:0]  o_rd,
  output logic               o_reg_write,
  output logic               o_illegal,
  output logic [NB_CNT-1:0]  o_issue_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [NB_OP-1:0] F_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] F_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] F_AND = 6'b100100;
  localparam logic [NB_OP-1:0] F_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] F_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] F_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] F_SRL = 6'b000010;
  localparam logic [NB_OP-1:0] F_SRA = 6'b000011;

  // Packed op: {data_1, data_2, code, rd, reg_write, illegal}
  localparam int unsigned NB_ENTRY = 2 * NB_DATA + NB_OP + NB_REG + 2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [NB_ENTRY-1:0] r_main;
  logic [NB_ENTRY-1:0] r_skid;
  logic [NB_ENTRY-1:0] w_main_next;
  logic                w_load_main;
  logic                w_load_skid;
  logic [NB_CNT-1:0]   r_count;

  logic [NB_DATA-1:0]  w_d1;
  logic [NB_DATA-1:0]  w_d2;
  logic [NB_OP-1:0]    w_code;
  logic [NB_REG-1:0]   w_rd;
  logic                w_legal;
  logic                w_reg_write;
  logic [NB_ENTRY-1:0] w_dec;

  logic [5:0]          w_opcode;
  logic [NB_OP-1:0]    w_funct;
  logic [15:0]         w_imm;
  logic [NB_DATA-1:0]  w_shamt_zx;
  logic [NB_DATA-1:0]  w_rs_shamt_zx;
  logic                w_accept;
  logic                w_issue;
  logic                w_unused;

  assign w_opcode      = i_instr[31:26];
  assign w_funct       = i_instr[5:0];
  assign w_imm         = i_instr[15:0];
  assign w_shamt_zx    = {{(NB_DATA-5){1'b0}}, i_instr[10:6]};
  assign w_rs_shamt_zx = {{(NB_DATA-5){1'b0}}, i_rs_data[4:0]};
  // rs field is not needed: its value arrives on i_rs_data
  assign w_unused      = ^i_instr[25:21];

  assign o_ready  = (r_state != ST_FULL);
  assign o_valid  = (r_state != ST_EMPTY);
  assign w_accept = i_valid & o_ready;
  assign w_issue  = o_valid & i_ex_ready;

  // Combinational decode of the incoming instruction
  always_comb begin
    w_d1    = '0;
    w_d2    = '0;
    w_code  = '0;
    w_rd    = '0;
    w_legal = 1'b0;
    if (w_opcode == 6'b000000) begin
      w_rd    = i_instr[15:11];
      w_legal = 1'b1;
      case (w_funct)
        F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR: begin
          w_d1 = i_rs_data; w_d2 = i_rt_data; w_code = w_funct;
        end
        F_SRL, F_SRA: begin
          w_d1 = i_rt_data; w_d2 = w_shamt_zx; w_code = w_funct;
        end
        6'b000110: begin
          w_d1 = i_rt_data; w_d2 = w_rs_shamt_zx; w_code = F_SRL;
        end
        6'b000111: begin
          w_d1 = i_rt_data; w_d2 = w_rs_shamt_zx; w_code = F_SRA;
        end
        default: begin
          w_legal = 1'b0; w_rd = '0;
        end
      endcase
    end else begin
      w_rd    = i_instr[20:16];
      w_legal = 1'b1;
      w_d1    = i_rs_data;
      case (w_opcode)
        6'b001000: begin w_code = F_ADD; w_d2 = {{(NB_DATA-16){w_imm[15]}}, w_imm}; end
        6'b001100: begin w_code = F_AND; w_d2 = {{(NB_DATA-16){1'b0}}, w_imm}; end
        6'b001101: begin w_code = F_OR;  w_d2 = {{(NB_DATA-16){1'b0}}, w_imm}; end
        6'b001110: begin w_code = F_XOR; w_d2 = {{(NB_DATA-16){1'b0}}, w_imm}; end
        6'b001111: begin w_code = F_OR;  w_d1 = '0; w_d2 = {w_imm, {(NB_DATA-16){1'b0}}}; end
        default: begin
          w_legal = 1'b0; w_rd = '0; w_d1 = '0;
        end
      endcase
    end
  end

  assign w_reg_write = w_legal & (w_rd != '0);
  assign w_dec       = {w_d1, w_d2, w_code, w_rd, w_reg_write, ~w_legal};

  // Next-state and register-load selection; flush overrides everything
  always_comb begin
    w_state_next = r_state;
    w_load_main  = 1'b0;
    w_load_skid  = 1'b0;
    w_main_next  = w_dec;
    if (i_flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_BUSY;
            w_load_main  = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_accept && w_issue) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_state_next = ST_FULL;
            w_load_skid  = 1'b1;
          end else if (w_issue) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_issue) begin
            w_state_next = ST_BUSY;
            w_load_main  = 1'b1;
            w_main_next  = r_skid;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // State, main and skid registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_main) r_main <= w_main_next;
      if (w_load_skid) r_skid <= w_dec;
    end
  end

  // Issue counter; an issue in a flush cycle still counts
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (w_issue) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign {o_data_1, o_data_2, o_code, o_rd, o_reg_write, o_illegal} = r_main;
  assign o_issue_count = r_count;

endmodule

// File: tb/tb_id_alu_issue.sv
// Scoreboard bench for id_alu_issue: the driver pushes the expected decode of
// every accepted instruction; a negedge monitor pops and compares on issue.
module tb_id_alu_issue;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [5:0]  code;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  logic        i_clk, i_reset, i_valid, o_ready, i_flush, o_valid, i_ex_ready;
  logic [31:0] i_instr, i_rs_data, i_rt_data, o_data_1, o_data_2;
  logic [5:0]  o_code;
  logic [4:0]  o_rd;
  logic        o_reg_write, o_illegal;
  logic [15:0] o_issue_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        q[$];
  int          occ      = 0;
  logic [15:0] exp_cnt  = '0;

  id_alu_issue dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_instr      (i_instr),
    .i_rs_data    (i_rs_data),
    .i_rt_data    (i_rt_data),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ex_ready   (i_ex_ready),
    .o_data_1     (o_data_1),
    .o_data_2     (o_data_2),
    .o_code       (o_code),
    .o_rd         (o_rd),
    .o_reg_write  (o_reg_write),
    .o_illegal    (o_illegal),
    .o_issue_count(o_issue_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected ALU-side view of an instruction, straight from the ISA rules
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rsd,
                                 input logic [31:0] rtd);
    exp_t        e;
    logic [15:0] imm;
    logic [5:0]  op, fn;
    imm = ins[15:0];
    op  = ins[31:26];
    fn  = ins[5:0];
    e   = '0;
    if (op == 6'h00) begin
      e.rd = ins[15:11];
      case (fn)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27: begin e.d1 = rsd; e.d2 = rtd; e.code = fn; end
        6'h02, 6'h03: begin e.d1 = rtd; e.d2 = {27'd0, ins[10:6]}; e.code = fn; end
        6'h06: begin e.d1 = rtd; e.d2 = {27'd0, rsd[4:0]}; e.code = 6'h02; end
        6'h07: begin e.d1 = rtd; e.d2 = {27'd0, rsd[4:0]}; e.code = 6'h03; end
        default: e.ill = 1'b1;
      endcase
    end else begin
      e.rd = ins[20:16];
      e.d1 = rsd;
      case (op)
        6'h08: begin e.code = 6'h20; e.d2 = {{16{imm[15]}}, imm}; end
        6'h0C: begin e.code = 6'h24; e.d2 = {16'd0, imm}; end
        6'h0D: begin e.code = 6'h25; e.d2 = {16'd0, imm}; end
        6'h0E: begin e.code = 6'h26; e.d2 = {16'd0, imm}; end
        6'h0F: begin e.code = 6'h25; e.d1 = 32'd0; e.d2 = {imm, 16'd0}; end
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e     = '0;
      e.ill = 1'b1;
    end
    e.rw = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fn_tab [0:9];
    logic [5:0]  op_tab [0:4];
    logic [31:0] w;
    int          k;
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03, 6'h06, 6'h07};
    op_tab = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    w = $urandom;
    k = $urandom_range(0, 15);
    if (k < 8) begin
      w[31:26] = 6'h00;
      w[5:0]   = fn_tab[$urandom_range(0, 9)];
    end else if (k < 13) begin
      w[31:26] = op_tab[$urandom_range(0, 4)];
    end
    return w;
  endfunction

  // One clock of stimulus; pushes the expectation when the op will be accepted
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic exr, input logic fl,
                       output logic accepted);
    @(posedge i_clk);
    #1;
    i_valid    = v;
    i_instr    = ins;
    i_rs_data  = rs;
    i_rt_data  = rt;
    i_ex_ready = exr;
    i_flush    = fl;
    accepted   = v && o_ready && !fl && !i_reset;
    if (accepted) q.push_back(model(ins, rs, rt));
  endtask

  task automatic idle(input logic exr);
    logic a;
    cycle(1'b0, 32'd0, 32'd0, 32'd0, exr, 1'b0, a);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                      input logic exr);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      cycle(1'b1, ins, rs, rt, exr, 1'b0, a);
      n++;
    end
    if (!a) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || o_valid) && n < 20) begin
      idle(1'b1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_data", {o_data_1, o_data_2}, 0);
    chk("rst_code_rd", {o_code, o_rd}, 0);
    chk("rst_flags", {o_reg_write, o_illegal}, 0);
    chk("rst_count", o_issue_count, 0);
  endtask

  // Monitor: handshake occupancy model plus scoreboard pop on each issue
  exp_t e_mon;
  logic acc_mon, iss_mon;
  always @(negedge i_clk) begin
    if (i_reset) begin
      q.delete();
      occ     = 0;
      exp_cnt = '0;
    end else begin
      chk("ready_vs_occ", o_ready, occ < 2);
      chk("valid_vs_occ", o_valid, occ > 0);
      acc_mon = i_valid && o_ready;
      iss_mon = o_valid && i_ex_ready;
      if (iss_mon) begin
        if (q.size() == 0) begin
          chk("issue_without_expect", 1, 0);
        end else begin
          e_mon = q.pop_front();
          chk("op_fields", {o_data_1, o_data_2, o_code, o_reg_write, o_illegal},
              {e_mon.d1, e_mon.d2, e_mon.code, e_mon.rw, e_mon.ill});
          if (!e_mon.ill) chk("op_rd", o_rd, e_mon.rd);
          chk("op_count", o_issue_count, exp_cnt);
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      if (i_flush) begin
        q.delete();
        occ = 0;
      end else begin
        occ = occ + int'(acc_mon) - int'(iss_mon);
      end
    end
  end

  logic [15:0] cnt_saved;
  logic        a_dummy;

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_instr = '0; i_rs_data = '0; i_rt_data = '0;
    i_flush = 1'b0; i_ex_ready = 1'b0;
    #1 i_reset = 1'b1;
    #1 chk_reset_outputs();
    @(negedge i_clk);
    #1 i_reset = 1'b0;

    // ADD $3,$1,$2
    send(r_ins(1, 2, 3, 0, 6'h20), 32'd5, 32'd7, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("add_count", o_issue_count, 1);

    // SRA $4,$2,3 then ADDI $5,$1,-2
    send(r_ins(0, 2, 4, 3, 6'h03), 32'd0, 32'hF000_0000, 1'b1);
    send(i_ins(6'h08, 1, 5, 16'hFFFE), 32'd10, 32'd0, 1'b1);
    drain();

    // Back-pressure: A,B fill the stage, C waits until A issues
    send(r_ins(1, 2, 7, 0, 6'h22), 32'd100, 32'd1, 1'b0);
    send(r_ins(1, 2, 8, 0, 6'h24), 32'hFF00, 32'h0FF0, 1'b0);
    cycle(1'b1, r_ins(1, 2, 9, 0, 6'h26), 32'hAAAA, 32'h5555, 1'b0, 1'b0, a_dummy);
    chk("full_not_ready", o_ready, 0);
    cycle(1'b1, r_ins(1, 2, 9, 0, 6'h26), 32'hAAAA, 32'h5555, 1'b0, 1'b0, a_dummy);
    send(r_ins(1, 2, 9, 0, 6'h26), 32'hAAAA, 32'h5555, 1'b1);
    drain();

    // Flush while FULL with a valid input present
    send(i_ins(6'h0D, 1, 10, 16'h00F0), 32'h1, 32'd0, 1'b0);
    send(i_ins(6'h0E, 1, 11, 16'h0F0F), 32'h2, 32'd0, 1'b0);
    cnt_saved = exp_cnt;
    cycle(1'b1, i_ins(6'h0C, 1, 12, 16'hFFFF), 32'h3, 32'd0, 1'b0, 1'b1, a_dummy);
    idle(1'b0);
    chk("flush_valid", o_valid, 0);
    chk("flush_ready", o_ready, 1);
    chk("flush_count", o_issue_count, cnt_saved);
    idle(1'b1);
    chk("flush_no_ghost", o_valid, 0);

    // Illegal LW, then ADD with rd=0
    send(i_ins(6'h23, 1, 13, 16'h0004), 32'h44, 32'h55, 1'b1);
    send(r_ins(1, 2, 0, 0, 6'h20), 32'd3, 32'd4, 1'b1);
    drain();

    // Asynchronous reset mid-BUSY, then LUI $6,0x1234
    send(r_ins(1, 2, 14, 0, 6'h25), 32'h123, 32'h456, 1'b0);
    idle(1'b0);
    @(posedge i_clk);
    #3 i_reset = 1'b1;
    #1 chk_reset_outputs();
    @(negedge i_clk);
    #1 i_reset = 1'b0;
    send(i_ins(6'h0F, 0, 6, 16'h1234), 32'hDEAD_BEEF, 32'd0, 1'b1);
    drain();

    // Randomized traffic with back-pressure and occasional flushes
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0), a_dummy);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
